// File: rtl/bcd_timer_ctrl.sv
// Run controller for a two-digit BCD timer: load/target register, step prescaler and run FSM.
// Define BCD_TIMER_AUTORELOAD_EN for periodic mode (one-cycle alarm pulse, counter reloads, stays in RUN).
module bcd_timer_ctrl #(
    parameter int LIMIT_MSB = 5,
    parameter int TICK_DIV  = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       dir_i,
    input  logic [3:0] preset_high_i,
    input  logic [3:0] preset_low_i,
    output logic [3:0] high_o,
    output logic [3:0] low_o,
    output logic [1:0] state_o,
    output logic       alarm_o,
    output logic       load_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);
    localparam logic [3:0] HIGH_MAX   = 4'(LIMIT_MSB);

    state_e     state_q, state_d;
    logic [3:0] cntHigh_q, cntHigh_d;
    logic [3:0] cntLow_q, cntLow_d;
    logic [3:0] tgtHigh_q, tgtHigh_d;
    logic [3:0] tgtLow_q, tgtLow_d;
    logic [7:0] presc_q, presc_d;
    logic       dirUp_q, dirUp_d;
    logic       alarm_q, alarm_d;
    logic       loadErr_q, loadErr_d;
`ifdef BCD_TIMER_AUTORELOAD_EN
    logic       reloadPending_q, reloadPending_d;
`endif

    logic [3:0] upHigh, upLow, dnHigh, dnLow;
    logic [3:0] stepHigh, stepLow;
    logic       presetValid;
    logic       tgtIsZero;

    function automatic logic isTerminal(input logic [3:0] h, input logic [3:0] l,
                                        input logic [3:0] th, input logic [3:0] tl,
                                        input logic up);
        if (up) begin
            return (h == th) && (l == tl);
        end
        return (h == 4'd0) && (l == 4'd0);
    endfunction

    always_comb begin
        upLow    = (cntLow_q == 4'd9) ? 4'd0 : cntLow_q + 4'd1;
        upHigh   = (cntLow_q == 4'd9) ? cntHigh_q + 4'd1 : cntHigh_q;
        dnLow    = (cntLow_q == 4'd0) ? 4'd9 : cntLow_q - 4'd1;
        dnHigh   = (cntLow_q == 4'd0) ? cntHigh_q - 4'd1 : cntHigh_q;
        stepHigh = dirUp_q ? upHigh : dnHigh;
        stepLow  = dirUp_q ? upLow : dnLow;
        presetValid = (preset_low_i <= 4'd9) && (preset_high_i <= HIGH_MAX);
        tgtIsZero   = (tgtHigh_q == 4'd0) && (tgtLow_q == 4'd0);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            cntHigh_q <= 4'd0;
            cntLow_q  <= 4'd0;
            tgtHigh_q <= 4'd0;
            tgtLow_q  <= 4'd0;
            presc_q   <= 8'd0;
            dirUp_q   <= 1'b0;
            alarm_q   <= 1'b0;
            loadErr_q <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reloadPending_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cntHigh_q <= cntHigh_d;
            cntLow_q  <= cntLow_d;
            tgtHigh_q <= tgtHigh_d;
            tgtLow_q  <= tgtLow_d;
            presc_q   <= presc_d;
            dirUp_q   <= dirUp_d;
            alarm_q   <= alarm_d;
            loadErr_q <= loadErr_d;
`ifdef BCD_TIMER_AUTORELOAD_EN
            reloadPending_q <= reloadPending_d;
`endif
        end
    end

    // Commands that are ignored in the current state fall through to the next one down.
    always_comb begin
        state_d   = state_q;
        cntHigh_d = cntHigh_q;
        cntLow_d  = cntLow_q;
        tgtHigh_d = tgtHigh_q;
        tgtLow_d  = tgtLow_q;
        presc_d   = presc_q;
        dirUp_d   = dirUp_q;
        alarm_d   = alarm_q;
        loadErr_d = 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
        reloadPending_d = 1'b0;
        alarm_d         = alarm_q && (state_q == DONE);
`endif
        if (clear_i) begin
            state_d   = IDLE;
            cntHigh_d = 4'd0;
            cntLow_d  = 4'd0;
            tgtHigh_d = 4'd0;
            tgtLow_d  = 4'd0;
            presc_d   = 8'd0;
            dirUp_d   = 1'b0;
            alarm_d   = 1'b0;
        end else if (stop_i && (state_q == RUN)) begin
            state_d = PAUSED;
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (reloadPending_q) begin
                cntHigh_d = dirUp_q ? 4'd0 : tgtHigh_q;
                cntLow_d  = dirUp_q ? 4'd0 : tgtLow_q;
            end
`endif
        end else if (start_i && (state_q != RUN)) begin
            presc_d = 8'd0;
            state_d = RUN;
            unique case (state_q)
                IDLE: begin
                    dirUp_d = dir_i;
                    if (isTerminal(cntHigh_q, cntLow_q, tgtHigh_q, tgtLow_q, dir_i)) begin
                        state_d = DONE;
                        alarm_d = 1'b1;
                    end
                end
                PAUSED: begin
                    if (isTerminal(cntHigh_q, cntLow_q, tgtHigh_q, tgtLow_q, dirUp_q)) begin
                        state_d = DONE;
                        alarm_d = 1'b1;
                    end
                end
                default: begin
                    // Restart from DONE: start value equals terminal only when the target is 00.
                    dirUp_d   = dir_i;
                    cntHigh_d = dir_i ? 4'd0 : tgtHigh_q;
                    cntLow_d  = dir_i ? 4'd0 : tgtLow_q;
                    alarm_d   = tgtIsZero;
                    if (tgtIsZero) begin
                        state_d = DONE;
                    end
                end
            endcase
        end else if (load_i && ((state_q == IDLE) || (state_q == PAUSED))) begin
            if (presetValid) begin
                tgtHigh_d = preset_high_i;
                tgtLow_d  = preset_low_i;
                cntHigh_d = dir_i ? 4'd0 : preset_high_i;
                cntLow_d  = dir_i ? 4'd0 : preset_low_i;
            end else begin
                loadErr_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            presc_d = (presc_q == PRESC_LAST) ? 8'd0 : presc_q + 8'd1;
`ifdef BCD_TIMER_AUTORELOAD_EN
            if (reloadPending_q) begin
                cntHigh_d = dirUp_q ? 4'd0 : tgtHigh_q;
                cntLow_d  = dirUp_q ? 4'd0 : tgtLow_q;
            end else
`endif
            if (presc_q == PRESC_LAST) begin
                cntHigh_d = stepHigh;
                cntLow_d  = stepLow;
                if (isTerminal(stepHigh, stepLow, tgtHigh_q, tgtLow_q, dirUp_q)) begin
                    alarm_d = 1'b1;
`ifdef BCD_TIMER_AUTORELOAD_EN
                    reloadPending_d = 1'b1;
`else
                    state_d = DONE;
`endif
                end
            end
        end
    end

    always_comb begin
        high_o     = cntHigh_q;
        low_o      = cntLow_q;
        state_o    = state_q;
        alarm_o    = alarm_q;
        load_err_o = loadErr_q;
    end

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl (LIMIT_MSB=5, TICK_DIV=4).
// Builds with BCD_TIMER_AUTORELOAD_EN select the periodic-mode sequence instead of the one-shot one.
module tb_bcd_timer_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start, stop, clear, load, dir;
    logic [3:0] presetHigh, presetLow;
    logic [3:0] high, low;
    logic [1:0] state;
    logic       alarm, loadErr;

    int checkCount = 0;
    int errorCount = 0;

    bcd_timer_ctrl #(.LIMIT_MSB(5), .TICK_DIV(4)) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .stop_i       (stop),
        .clear_i      (clear),
        .load_i       (load),
        .dir_i        (dir),
        .preset_high_i(presetHigh),
        .preset_low_i (presetLow),
        .high_o       (high),
        .low_o        (low),
        .state_o      (state),
        .alarm_o      (alarm),
        .load_err_o   (loadErr)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkCounter(input string tag, input int value);
        checkOutput({tag, " high"}, 32'(high), 32'(value / 10));
        checkOutput({tag, " low"}, 32'(low), 32'(value % 10));
    endtask

    task automatic checkStatus(input string tag, input int expState, input int expAlarm);
        checkOutput({tag, " state"}, 32'(state), 32'(expState));
        checkOutput({tag, " alarm"}, 32'(alarm), 32'(expAlarm));
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    // Drives one cycle of strobes (sampled by the next rising edge) and returns after that edge.
    task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic ld,
                                 input logic d, input logic [3:0] ph, input logic [3:0] pl);
        start = st; stop = sp; clear = cl; load = ld; dir = d;
        presetHigh = ph; presetLow = pl;
        @(negedge clock);
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0; dir = 1'b0;
        presetHigh = 4'd0; presetLow = 4'd0;
        repeat (2) nextCycle();
        checkCounter("reset", 0);
        checkStatus("reset", 0, 0);
        checkOutput("reset loadErr", 32'(loadErr), 0);
        reset = 1'b0;
        nextCycle();

`ifdef BCD_TIMER_AUTORELOAD_EN
        applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd3);
        checkCounter("auto load", 3);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("auto start", 1, 0);
        for (int k = 1; k <= 36; k++) begin
            int p;
            p = k % 12;
            nextCycle();
            checkCounter($sformatf("auto k=%0d", k), (p == 0) ? 0 : 3 - p / 4);
            checkStatus($sformatf("auto k=%0d", k), 1, (p == 0) ? 1 : 0);
        end
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0);
        checkCounter("auto stop reload", 3);
        checkStatus("auto stop reload", 2, 0);
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0);
        checkStatus("auto start at terminal", 3, 1);
        repeat (3) nextCycle();
        checkStatus("auto done holds", 3, 1);
`else
        applyStimulus(0, 0, 0, 1, 0, 4'h6, 4'hA);
        checkOutput("invalid load loadErr", 32'(loadErr), 1);
        checkCounter("invalid load", 0);
        checkOutput("invalid load state", 32'(state), 0);
        nextCycle();
        checkOutput("loadErr one cycle", 32'(loadErr), 0);
        // Target must still be 00, so an up start is already at terminal.
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0);
        checkStatus("target unchanged", 3, 1);
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0);
        checkStatus("clear from done", 0, 0);

        applyStimulus(0, 0, 0, 1, 0, 4'd1, 4'd2);
        checkCounter("load 12 down", 12);
        checkOutput("valid load loadErr", 32'(loadErr), 0);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("down start", 1, 0);
        checkCounter("down start", 12);
        for (int k = 1; k <= 48; k++) begin
            nextCycle();
            checkCounter($sformatf("down k=%0d", k), 12 - k / 4);
            if (k >= 47) begin
                checkStatus($sformatf("down k=%0d", k), (k == 48) ? 3 : 1, (k == 48) ? 1 : 0);
            end
        end
        repeat (5) nextCycle();
        checkStatus("down done holds", 3, 1);
        checkCounter("down done holds", 0);

        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0);
        applyStimulus(0, 0, 0, 1, 1, 4'd1, 4'd5);
        checkCounter("load 15 up", 0);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0);
        for (int k = 1; k <= 60; k++) begin
            nextCycle();
            checkCounter($sformatf("up k=%0d", k), k / 4);
            if (k >= 59) begin
                checkStatus($sformatf("up k=%0d", k), (k == 60) ? 3 : 1, (k == 60) ? 1 : 0);
            end
        end

        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("restart down from done", 1, 0);
        checkCounter("restart down from done", 15);
        for (int k = 1; k <= 33; k++) begin
            nextCycle();
            checkCounter($sformatf("restart k=%0d", k), 15 - k / 4);
        end
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("pause", 2, 0);
        checkCounter("pause", 7);
        repeat (20) nextCycle();
        checkStatus("pause held", 2, 0);
        checkCounter("pause held", 7);
        // dir=1 on resume must be ignored: latched direction stays down.
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0);
        checkStatus("resume", 1, 0);
        for (int k = 1; k <= 4; k++) begin
            nextCycle();
            checkCounter($sformatf("resume k=%0d", k), (k < 4) ? 7 : 6);
        end
        repeat (3) nextCycle();
        checkCounter("before stop on wrap", 6);
        applyStimulus(0, 1, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("stop on wrap", 2, 0);
        checkCounter("stop on wrap", 6);

        applyStimulus(0, 0, 0, 1, 0, 4'd5, 4'd9);
        checkCounter("paused load 59", 59);
        checkOutput("paused load 59 loadErr", 32'(loadErr), 0);
        applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd3);
        checkCounter("paused load 03", 3);

        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        checkStatus("resume 03", 1, 0);
        repeat (2) nextCycle();
        applyStimulus(1, 0, 1, 0, 0, 4'd0, 4'd0);
        checkStatus("clear+start", 0, 0);
        checkCounter("clear+start", 0);

        applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd1);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        repeat (3) nextCycle();
        checkCounter("before clear on terminal", 1);
        applyStimulus(0, 0, 1, 0, 0, 4'd0, 4'd0);
        checkStatus("clear on terminal", 0, 0);
        checkCounter("clear on terminal", 0);

        applyStimulus(0, 0, 0, 1, 0, 4'd0, 4'd5);
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 4'd0);
        repeat (6) nextCycle();
        checkCounter("midrun", 4);
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        checkStatus("midrun reset", 0, 0);
        checkCounter("midrun reset", 0);
        applyStimulus(1, 0, 0, 0, 1, 4'd0, 4'd0);
        checkStatus("target cleared by reset", 3, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
